// File: rtl/banked_register_file.sv
// Architectural register file: 3 combinational read ports, 1 byte-enabled write port
// on the falling clock edge, optional write bypass, PC-mapped top entry, pending scoreboard.
module banked_register_file #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 16,
  localparam int              ADDR_W      = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               BYPASS      = 1'b1,
  parameter bit               PC_MAP      = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_wa,
  input  logic [WIDTH-1:0]    i_wd,
  input  logic [WIDTH/8-1:0]  i_be,
  input  logic [ADDR_W-1:0]   i_ra1,
  input  logic [ADDR_W-1:0]   i_ra2,
  input  logic [ADDR_W-1:0]   i_ra3,
  output logic [WIDTH-1:0]    o_rd1,
  output logic [WIDTH-1:0]    o_rd2,
  output logic [WIDTH-1:0]    o_rd3,
  input  logic [WIDTH-1:0]    i_pc_in,
  input  logic                i_issue,
  input  logic [ADDR_W-1:0]   i_issue_addr,
  output logic                o_busy1,
  output logic                o_busy2,
  output logic                o_busy3,
  output logic [DEPTH-1:0]    o_pending
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pending;
  logic             w_store_en;
  logic [DEPTH-1:0] w_pending_nxt;

  assign w_store_en = i_we && !(PC_MAP && (i_wa == PC_ADDR));

  // Clear from the retiring write first, then set from the new producer so it wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_we)    w_pending_nxt[i_wa]         = 1'b0;
    if (i_issue) w_pending_nxt[i_issue_addr] = 1'b1;
  end

  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < DEPTH; r++) r_mem[r] <= RESET_VALUE;
      r_pending <= '0;
    end else begin
      if (w_store_en) begin
        for (int b = 0; b < NB; b++)
          if (i_be[b]) r_mem[i_wa][8*b +: 8] <= i_wd[8*b +: 8];
      end
      r_pending <= w_pending_nxt;
    end
  end

  function automatic logic [WIDTH-1:0] f_read(
    input logic [ADDR_W-1:0] ra,
    input logic [WIDTH-1:0]  stored,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd,
    input logic [NB-1:0]     be,
    input logic [WIDTH-1:0]  pc
  );
    logic [WIDTH-1:0] v;
    v = stored;
    if (PC_MAP && (ra == PC_ADDR)) begin
      v = pc;
    end else if (BYPASS && we && (ra == wa)) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
    end
    return v;
  endfunction

  assign o_rd1 = f_read(i_ra1, r_mem[i_ra1], i_we, i_wa, i_wd, i_be, i_pc_in);
  assign o_rd2 = f_read(i_ra2, r_mem[i_ra2], i_we, i_wa, i_wd, i_be, i_pc_in);
  assign o_rd3 = f_read(i_ra3, r_mem[i_ra3], i_we, i_wa, i_wd, i_be, i_pc_in);

  // BUSY comes from the registered vector; the PC entry never stalls.
  assign o_busy1 = r_pending[i_ra1] && !(PC_MAP && (i_ra1 == PC_ADDR));
  assign o_busy2 = r_pending[i_ra2] && !(PC_MAP && (i_ra2 == PC_ADDR));
  assign o_busy3 = r_pending[i_ra3] && !(PC_MAP && (i_ra3 == PC_ADDR));

  assign o_pending = r_pending;

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file with hand-computed expectations.
module tb_banked_register_file;

  logic        clk = 1'b1;
  logic        rst;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [3:0]  be;
  logic [3:0]  ra1, ra2, ra3;
  logic [31:0] rd1, rd2, rd3;
  logic [31:0] pc_in;
  logic        issue;
  logic [3:0]  issue_addr;
  logic        busy1, busy2, busy3;
  logic [15:0] pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  banked_register_file dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_wa(wa), .i_wd(wd), .i_be(be),
    .i_ra1(ra1), .i_ra2(ra2), .i_ra3(ra3),
    .o_rd1(rd1), .o_rd2(rd2), .o_rd3(rd3),
    .i_pc_in(pc_in), .i_issue(issue), .i_issue_addr(issue_addr),
    .o_busy1(busy1), .o_busy2(busy2), .o_busy3(busy3),
    .o_pending(pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; be = '0;
    ra1 = '0; ra2 = '0; ra3 = '0; pc_in = 32'h0000_0108;
    issue = 1'b0; issue_addr = '0;
    #12;
    chk("rst_pending", {16'h0, pending}, 32'h0);
    rst = 1'b0;
    #1;

    for (int a = 0; a < 16; a++) begin
      ra1 = 4'(a); ra2 = 4'(a); ra3 = 4'(a);
      #1;
      chk("rst_rd1", rd1, (a == 15) ? 32'h108 : 32'h0);
      chk("rst_rd2", rd2, (a == 15) ? 32'h108 : 32'h0);
      chk("rst_rd3", rd3, (a == 15) ? 32'h108 : 32'h0);
    end
    chk("rst_pending2", {16'h0, pending}, 32'h0);

    // partial byte write with bypass
    tick();
    we = 1'b1; wa = 4'd3; wd = 32'hDEAD_BEEF; be = 4'b0101; ra1 = 4'd3; ra2 = 4'd3;
    #1;
    chk("byp_rd1", rd1, 32'h00AD_00EF);
    tick();
    we = 1'b0;
    #1;
    chk("wr_rd1", rd1, 32'h00AD_00EF);
    we = 1'b1; wd = 32'h1122_3344; be = 4'b1010;
    #1;
    chk("byp_merge", rd2, 32'h11AD_33EF);
    tick();
    wd = 32'hFFFF_FFFF; be = 4'b0000;
    #1;
    chk("be0_byp", rd1, 32'h11AD_33EF);
    tick();
    we = 1'b0;
    #1;
    chk("be0_hold", rd1, 32'h11AD_33EF);

    // PC mapping and PC busy suppression
    issue = 1'b1; issue_addr = 4'd15; ra2 = 4'd15;
    tick();
    issue = 1'b0;
    #1;
    chk("pc_pend_set", {16'h0, pending}, 32'h0000_8000);
    chk("pc_busy0", {31'h0, busy2}, 32'h0);
    we = 1'b1; wa = 4'd15; wd = 32'h5; be = 4'hF;
    #1;
    chk("pc_rd_wr", rd2, 32'h108);
    tick();
    we = 1'b0;
    #1;
    chk("pc_rd_after", rd2, 32'h108);
    chk("pc_pend_clr", {16'h0, pending}, 32'h0);

    // scoreboard
    issue = 1'b1; issue_addr = 4'd7; ra3 = 4'd7;
    #1;
    chk("busy_pre", {31'h0, busy3}, 32'h0);
    tick();
    issue = 1'b0;
    #1;
    chk("pend_7", {16'h0, pending}, 32'h0000_0080);
    chk("busy3_7", {31'h0, busy3}, 32'h1);
    we = 1'b1; wa = 4'd7; wd = 32'hCAFE_F00D; be = 4'hF; issue = 1'b1; issue_addr = 4'd7;
    #1;
    chk("busy_byp", {31'h0, busy3}, 32'h1);
    chk("rd3_byp", rd3, 32'hCAFE_F00D);
    tick();
    issue = 1'b1; issue_addr = 4'd9; we = 1'b0;
    #1;
    chk("pend_wins", {16'h0, pending}, 32'h0000_0080);
    tick();
    issue = 1'b1; issue_addr = 4'd9;
    #1;
    chk("pend_7_9", {16'h0, pending}, 32'h0000_0280);
    tick();
    issue = 1'b0; we = 1'b1; wa = 4'd7; wd = 32'h0; be = 4'h0;
    tick();
    we = 1'b0;
    #1;
    chk("pend_clr7", {16'h0, pending}, 32'h0000_0200);
    chk("rd3_be0", rd3, 32'hCAFE_F00D);

    // async reset between edges
    we = 1'b1; wa = 4'd2; wd = 32'h1234_5678; be = 4'hF; ra1 = 4'd2;
    tick();
    we = 1'b0;
    #1;
    chk("r2_before", rd1, 32'h1234_5678);
    we = 1'b1; wa = 4'd5; wd = 32'h5555_AAAA; ra2 = 4'd5;
    rst = 1'b1;
    #1;
    chk("rst_mid_rd1", rd1, 32'h0);
    chk("rst_mid_pend", {16'h0, pending}, 32'h0);
    #2;
    rst = 1'b0; we = 1'b0;
    tick();
    chk("rst_no_wr5", rd2, 32'h0);
    chk("rst_rd3", rd3, 32'h0);
    we = 1'b1; wa = 4'd2; wd = 32'hA5A5_A5A5; be = 4'hF;
    tick();
    we = 1'b0;
    #1;
    chk("resume_wr", rd1, 32'hA5A5_A5A5);

    // aliased read ports
    ra1 = 4'd4; ra2 = 4'd4; ra3 = 4'd4;
    we = 1'b1; wa = 4'd4; wd = 32'hFFFF_FFFF; be = 4'hF;
    #1;
    chk("alias_rd1", rd1, 32'hFFFF_FFFF);
    chk("alias_rd2", rd2, 32'hFFFF_FFFF);
    chk("alias_rd3", rd3, 32'hFFFF_FFFF);
    tick();
    we = 1'b0;
    #1;
    chk("alias_hold", rd2, 32'hFFFF_FFFF);
    ra1 = 4'd3;
    #1;
    chk("r3_untouched", rd1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
